// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM encoding and response record
//
// Purpose: constants and types shared by alu_arbiter and its bench.
// Ports:   none (package).
package alu_pkg;

  localparam int ALU_XLEN = 64;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Highest control code the shared ALU understands.
  localparam logic [3:0] ALU_OP_LAST = ALU_SLTU;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [ALU_XLEN-1:0] result;
    logic                zero;
    logic                carry;
    logic                overflow;
    logic                err;
  } rsp_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= ALU_OP_LAST;
  endfunction

  // Only the arithmetic ops expose the ALU's carry/overflow.
  function automatic logic op_has_flags(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin picker with priority pointer
//
// Purpose: picks one of two requesters; on a tie the priority pointer
//          decides, and after every grant the pointer moves to the loser.
// Ports:   clk, rst_n   clock, synchronous active-low reset
//          i_en         picking allowed this cycle (grant forced 0 otherwise)
//          i_req[1:0]   request vector
//          o_gnt[1:0]   one-hot grant (combinational)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_prp;
  logic [1:0] w_pick;

  always_comb begin
    w_pick = i_req;
    if (i_req == 2'b11) begin
      w_pick = r_prp ? 2'b10 : 2'b01;
    end
  end

  assign o_gnt = i_en ? w_pick : 2'b00;

  // Pointer becomes the loser of this grant: requester 0 wins -> prp = 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prp <= 1'b0;
    end else if (|o_gnt) begin
      r_prp <= o_gnt[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters
//
// Purpose: accepts one operation at a time from two requesters (round-robin),
//          drives it onto the external ALU for one cycle, registers the result
//          and flags into the winner's response slot and holds it until taken.
// Ports:   clk, rst_n                          clock, synchronous active-low reset
//          reqN_valid/ready/op/a/b (N=0,1)    operation request handshake
//          rspN_valid/ready/result/zero/carry/overflow/err  response handshake
//          alu_rs1, alu_rs2, alu_control       to the shared ALU
//          alu_rd, alu_carry, alu_overflow     from the shared ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,

  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_carry,
  output logic            rsp0_overflow,
  output logic            rsp0_err,

  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_carry,
  output logic            rsp1_overflow,
  output logic            rsp1_err,

  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_rd,
  input  logic            alu_carry,
  input  logic            alu_overflow
);

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_gnt_id;
  logic [XLEN-1:0] r_alu_rs1;
  logic [XLEN-1:0] r_alu_rs2;
  logic [3:0]      r_alu_ctl;
  logic            r_err;
  logic            r_flagged;
  rsp_t            r_rsp [0:1];

  logic            w_idle;
  logic [1:0]      w_gnt;
  logic            w_accept;
  logic [3:0]      w_sel_op;
  logic [XLEN-1:0] w_sel_a;
  logic [XLEN-1:0] w_sel_b;
  logic            w_sel_legal;
  logic            w_rsp_done;
  rsp_t            w_rsp_new;

  // Reset gates the grant so ready stays low while rst_n is held.
  assign w_idle = (r_state == ST_IDLE) && rst_n;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_idle),
    .i_req ({req1_valid, req0_valid}),
    .o_gnt (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_accept   = |w_gnt;

  assign w_sel_op    = w_gnt[1] ? req1_op : req0_op;
  assign w_sel_a     = w_gnt[1] ? req1_a  : req0_a;
  assign w_sel_b     = w_gnt[1] ? req1_b  : req0_b;
  assign w_sel_legal = op_is_legal(w_sel_op);

  assign w_rsp_done = r_gnt_id ? rsp1_ready : rsp0_ready;

  // Illegal ops still walk the ALU slot (with control 0) but report only err.
  always_comb begin
    w_rsp_new          = '0;
    w_rsp_new.valid    = 1'b1;
    w_rsp_new.err      = r_err;
    if (!r_err) begin
      w_rsp_new.result = alu_rd;
      w_rsp_new.zero   = (alu_rd == '0);
    end
    w_rsp_new.carry    = r_flagged & alu_carry;
    w_rsp_new.overflow = r_flagged & alu_overflow;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)   w_state_nxt = ST_ISSUE;
      ST_ISSUE:                 w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // The alu_* registers double as the operation latch: loaded on accept,
  // they present the op during ISSUE and simply hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt_id  <= 1'b0;
      r_alu_rs1 <= '0;
      r_alu_rs2 <= '0;
      r_alu_ctl <= '0;
      r_err     <= 1'b0;
      r_flagged <= 1'b0;
      r_rsp[0]  <= '0;
      r_rsp[1]  <= '0;
    end else begin
      if (w_accept) begin
        r_gnt_id  <= w_gnt[1];
        r_alu_rs1 <= w_sel_a;
        r_alu_rs2 <= w_sel_b;
        r_alu_ctl <= w_sel_legal ? w_sel_op : ALU_AND;
        r_err     <= !w_sel_legal;
        r_flagged <= w_sel_legal && op_has_flags(w_sel_op);
      end
      if (r_state == ST_ISSUE) begin
        r_rsp[r_gnt_id] <= w_rsp_new;
      end else if ((r_state == ST_RESP) && w_rsp_done) begin
        r_rsp[r_gnt_id] <= '0;
      end
    end
  end

  assign alu_rs1     = r_alu_rs1;
  assign alu_rs2     = r_alu_rs2;
  assign alu_control = r_alu_ctl;

  assign rsp0_valid    = r_rsp[0].valid;
  assign rsp0_result   = r_rsp[0].result;
  assign rsp0_zero     = r_rsp[0].zero;
  assign rsp0_carry    = r_rsp[0].carry;
  assign rsp0_overflow = r_rsp[0].overflow;
  assign rsp0_err      = r_rsp[0].err;

  assign rsp1_valid    = r_rsp[1].valid;
  assign rsp1_result   = r_rsp[1].result;
  assign rsp1_zero     = r_rsp[1].zero;
  assign rsp1_carry    = r_rsp[1].carry;
  assign rsp1_overflow = r_rsp[1].overflow;
  assign rsp1_err      = r_rsp[1].err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a stand-in ALU
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [63:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp0_carry, rsp0_overflow, rsp0_err;
  logic        rsp1_zero, rsp1_carry, rsp1_overflow, rsp1_err;
  logic [63:0] alu_rs1, alu_rs2, alu_rd;
  logic [3:0]  alu_control;
  logic        alu_carry, alu_overflow;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rand_rdy = 1'b0;
  logic frc0 = 1'b1, frc1 = 1'b1;

  typedef struct {
    logic [63:0] res;
    logic        z, c, v, e;
    int          t_acc;
    logic [3:0]  ctl;
    logic [63:0] a, b;
  } exp_t;

  exp_t q [2][$];

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_carry(rsp0_carry), .rsp0_overflow(rsp0_overflow),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_carry(rsp1_carry), .rsp1_overflow(rsp1_overflow),
    .rsp1_err(rsp1_err),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_control(alu_control),
    .alu_rd(alu_rd), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
  );

  // Stand-in ALU. carry/overflow are deliberately 1 for non-arithmetic ops so
  // that the arbiter's masking is visible.
  function automatic logic [65:0] alu_model(input logic [3:0] c, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] rd;
    logic cy, ov;
    cy = 1'b1;
    ov = 1'b1;
    case (c)
      ALU_AND:  rd = a & b;
      ALU_OR:   rd = a | b;
      ALU_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        rd = s[63:0];
        cy = s[64];
        ov = (a[63] == b[63]) && (rd[63] != a[63]);
      end
      ALU_XOR:  rd = a ^ b;
      ALU_SLL:  rd = a << b[5:0];
      ALU_SRL:  rd = a >> b[5:0];
      ALU_SUB: begin
        rd = a - b;
        cy = (a < b);
        ov = (a[63] != b[63]) && (rd[63] != a[63]);
      end
      ALU_SRA:  rd = $unsigned($signed(a) >>> b[5:0]);
      ALU_SLT:  rd = {63'd0, $signed(a) < $signed(b)};
      ALU_SLTU: rd = {63'd0, a < b};
      default:  rd = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    return {rd, cy, ov};
  endfunction

  always_comb begin
    {alu_rd, alu_carry, alu_overflow} = alu_model(alu_control, alu_rs1, alu_rs2);
  end

  // Reference response from the arbiter's rules.
  function automatic exp_t expect_rsp(input logic [3:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
    exp_t e;
    logic [63:0] rd;
    logic cy, ov;
    e.a = a;
    e.b = b;
    e.t_acc = 0;
    if (op > 4'd9) begin
      e.res = 64'd0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b1; e.ctl = 4'd0;
    end else begin
      {rd, cy, ov} = alu_model(op, a, b);
      e.res = rd;
      e.z   = (rd == 64'd0);
      e.c   = (op == 4'd2 || op == 4'd6) ? cy : 1'b0;
      e.v   = (op == 4'd2 || op == 4'd6) ? ov : 1'b0;
      e.e   = 1'b0;
      e.ctl = op;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'd0;
      2:       return 64'($urandom_range(0, 70));
      default: return 64'h7FFF_FFFF_FFFF_FFFF + 64'($urandom_range(0, 2));
    endcase
  endfunction

  task automatic drive(input int n, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output int t);
    exp_t e;
    int k;
    logic got;
    @(posedge clk); #1;
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    t = -1;
    got = 1'b0;
    k = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) got = 1'b1;
      else k++;
    end
    chk($sformatf("grant_wait_req%0d", n), {63'd0, got}, 64'd1);
    if (got) begin
      t = cyc;
      e = expect_rsp(op, a, b);
      e.t_acc = t;
      q[n].push_back(e);
    end
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic tie(input logic [3:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                     input logic [3:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                     output int t0, output int t1);
    int x0, x1;
    fork
      drive(0, op0, a0, b0, x0);
      drive(1, op1, a1, b1, x1);
    join
    t0 = x0;
    t1 = x1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || rsp0_valid || rsp1_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {63'd0, k < 200}, 64'd1);
  endtask

  task automatic rand_stream(input int n, input int cnt);
    int t;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      drive(n, 4'($urandom_range(0, 15)), rnd64(), rnd64(), t);
    end
  endtask

  initial begin : cyc_cnt
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : rsp_rdy_drv
    forever begin
      @(posedge clk); #1;
      rsp0_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : frc0;
      rsp1_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : frc1;
    end
  end

  // Monitor: checks each response when it first appears, checks it stays put
  // while stalled, and retires it on the handshake.
  initial begin : monitor
    logic        pv [2];
    logic        prdy [2];
    logic [67:0] pf [2];
    logic        v, r;
    logic [67:0] f;
    exp_t        e;
    pv[0] = 1'b0; pv[1] = 1'b0; prdy[0] = 1'b0; prdy[1] = 1'b0;
    pf[0] = '0; pf[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
      end else begin
        if (rsp0_valid || rsp1_valid)
          chk("ready_outside_idle", {62'd0, req1_ready, req0_ready}, 64'd0);
        if (rsp0_valid)
          chk("rsp1_quiet", {rsp1_valid, rsp1_zero, rsp1_carry, rsp1_overflow, rsp1_err} |
                            rsp1_result, 64'd0);
        if (rsp1_valid)
          chk("rsp0_quiet", {rsp0_valid, rsp0_zero, rsp0_carry, rsp0_overflow, rsp0_err} |
                            rsp0_result, 64'd0);
        for (int n = 0; n < 2; n++) begin
          v = (n == 0) ? rsp0_valid : rsp1_valid;
          r = (n == 0) ? rsp0_ready : rsp1_ready;
          f = (n == 0) ? {rsp0_result, rsp0_zero, rsp0_carry, rsp0_overflow, rsp0_err}
                       : {rsp1_result, rsp1_zero, rsp1_carry, rsp1_overflow, rsp1_err};
          if (v && !pv[n]) begin
            if (q[n].size() == 0) begin
              chk($sformatf("unexpected_rsp%0d", n), 64'd1, 64'd0);
            end else begin
              e = q[n][0];
              chk($sformatf("rsp%0d_result", n), f[67:4], e.res);
              chk($sformatf("rsp%0d_flags_zcve", n), {60'd0, f[3:0]},
                  {60'd0, e.z, e.c, e.v, e.e});
              chk($sformatf("rsp%0d_latency", n), 64'(cyc), 64'(e.t_acc + 2));
              chk($sformatf("rsp%0d_alu_control", n), {60'd0, alu_control}, {60'd0, e.ctl});
              chk($sformatf("rsp%0d_alu_rs1", n), alu_rs1, e.a);
              chk($sformatf("rsp%0d_alu_rs2", n), alu_rs2, e.b);
            end
          end else if (v && pv[n] && !prdy[n]) begin
            chk($sformatf("rsp%0d_stable_result", n), f[67:4], pf[n][67:4]);
            chk($sformatf("rsp%0d_stable_flags", n), {60'd0, f[3:0]}, {60'd0, pf[n][3:0]});
          end
          if (v && r && q[n].size() != 0) void'(q[n].pop_front());
          pv[n]   = v && !r;
          prdy[n] = r;
          pf[n]   = f;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1, k;
    logic seen;

    // Reset state, with a request held to show ready stays low.
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 64'd9; req0_b = 64'd9;
    repeat (3) @(negedge clk);
    chk("reset_req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("reset_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    chk("reset_rsp0_result", rsp0_result, 64'd0);
    chk("reset_alu_ctl", {60'd0, alu_control}, 64'd0);
    chk("reset_alu_rs1", alu_rs1 | alu_rs2, 64'd0);
    req0_valid = 1'b0;

    // Both requesters valid out of reset: req0 first, req1 at the next IDLE.
    fork
      drive(0, ALU_ADD, 64'd11, 64'd22, t0);
      drive(1, ALU_SUB, 64'd3, 64'd7, t1);
      begin @(posedge clk); #1; rst_n = 1'b1; end
    join
    chk("tie_reset_req0_first", {63'd0, t0 < t1}, 64'd1);
    chk("tie_reset_req1_next_idle", 64'(t1), 64'(t0 + 3));
    wait_idle();

    // Solo ADD 5 + -5.
    drive(0, ALU_ADD, 64'd5, -64'sd5, t0);
    wait_idle();

    // req0 was last winner, so the tie goes to req1.
    tie(ALU_AND, 64'hF0F0, 64'hFF00, ALU_OR, 64'h1, 64'h2, t0, t1);
    chk("tie_after_req0_req1_first", {63'd0, t1 < t0}, 64'd1);
    wait_idle();

    // Signed overflow, then a shift whose ALU flags must be masked.
    drive(1, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, t1);
    drive(1, ALU_SLL, 64'd1, 64'd63, t1);
    wait_idle();

    // Illegal op: ALU sees AND of all-ones, result must still be 0.
    drive(0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, t0);
    wait_idle();

    // rsp0 stalled for 5 cycles while req1 waits.
    frc0 = 1'b0;
    fork
      drive(0, ALU_XOR, 64'h1234, 64'h00FF, t0);
      begin @(posedge clk); drive(1, ALU_SLTU, 64'd1, 64'd2, t1); end
      begin
        seen = 1'b0;
        k = 0;
        while (!seen && k < 30) begin
          @(negedge clk);
          seen = rsp0_valid;
          k++;
        end
        chk("stall_rsp0_seen", {63'd0, seen}, 64'd1);
        for (int i = 0; i < 5; i++) begin
          chk("stall_req1_not_granted", {63'd0, req1_ready}, 64'd0);
          chk("stall_rsp0_held", {63'd0, rsp0_valid}, 64'd1);
          @(negedge clk);
        end
        frc0 = 1'b1;
      end
    join
    wait_idle();

    // Reset during ISSUE: operation vanishes, pointer returns to requester 0.
    drive(0, ALU_ADD, 64'd10, 64'd20, t0);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_req0_ready", {63'd0, req0_ready}, 64'd0);
    @(negedge clk);
    chk("rst_mid_req0_ready2", {63'd0, req0_ready}, 64'd0);
    chk("rst_mid_alu_cleared", alu_rs1 | alu_rs2 | {60'd0, alu_control}, 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    q[0].delete();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | rsp0_valid;
    end
    chk("rst_mid_no_rsp0", {63'd0, seen}, 64'd0);
    tie(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4, ALU_SLT, -64'sd1, 64'd1, t0, t1);
    chk("tie_after_reset_req0_first", {63'd0, t0 < t1}, 64'd1);
    wait_idle();

    // Randomized traffic from both sides with random response back-pressure.
    rand_rdy = 1'b1;
    fork
      rand_stream(0, 40);
      rand_stream(1, 40);
    join
    rand_rdy = 1'b0;
    wait_idle();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 64, operand/result width; the only legal value is 64.
REQ-002 Port: clk  in  1  rising-edge clock; the block uses one clock only.
REQ-003 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-004 Ports reqN_valid (N=0,1)  in  1  requester N presents an operation.
REQ-005 Ports reqN_ready  out  1  the operation of requester N is accepted this cycle.
REQ-006 Ports reqN_op  in  4  ALU control code.
REQ-007 Ports reqN_a, reqN_b  in  XLEN  operands rs1, rs2.
REQ-008 Ports rspN_valid  out  1  response held for requester N.
REQ-009 Ports rspN_ready  in  1  requester N consumes the response.
REQ-010 Ports rspN_result  out  XLEN  result.
REQ-011 Ports rspN_zero, rspN_carry, rspN_overflow, rspN_err  out  1 each  response flags.
REQ-012 Ports alu_rs1, alu_rs2  out  XLEN; alu_control  out  4; these drive the shared ALU.
REQ-013 Ports alu_rd  in  XLEN; alu_carry, alu_overflow  in  1; these are the ALU outputs.

Function
REQ-014 FSM states: IDLE, ISSUE, RESP.
REQ-015 IDLE: if any reqN_valid is high, the grant is chosen by round-robin and reqN_ready of the winner is asserted for exactly 1 cycle (combinational).
- Op and operands are latched on that edge.
- Next state is ISSUE.
REQ-016 Round-robin: on a tie, priority pointer prp decides. prp toggles to the loser after each grant. prp resets to requester 0.
REQ-017 A single valid requester is granted regardless of prp.
REQ-018 ISSUE: alu_* outputs present the latched op/operands. At the clock edge, the result and flags are registered into the granted requester's rsp registers. Next state is RESP.
REQ-019 RESP: rspN_valid of the granted requester is high and all rsp fields are stable until rspN_ready is high. Then, on the same edge, the state returns to IDLE.
REQ-020 Latency: if accepted at edge T, rspN_valid is high after edge T+2. The maximum throughput is one operation per 3 cycles.
REQ-021 No request is accepted outside IDLE. reqN_ready is 0 in ISSUE and RESP.
REQ-022 zero = (alu_rd == 0). It is computed locally for every legal op.
REQ-023 carry and overflow are taken from the ALU only for ADD (0010) and SUB (0110). For all other ops they are 0.
REQ-024 Legal ops are 0000-1001. For op 1010-1111: alu_control is driven 0000, result is 0, zero/carry/overflow are 0, and err is 1. Timing is unchanged.
REQ-025 alu_* outputs hold their last driven values outside ISSUE. After reset they are 0.
REQ-026 The rsp outputs of the non-granted requester stay 0 (valid 0).
REQ-027 A requester that holds reqN_valid while the other requester is served stays pending. It is not dropped.
REQ-028 Results are XLEN bits and are passed unmodified; no flags are derived beyond REQ-022 to REQ-024.

Reset
REQ-029 When rst_n is low at an edge, the following are cleared: state to IDLE, prp to 0, all rsp registers and valids to 0, and alu_* to 0.
REQ-030 Reset mid-operation (ISSUE or RESP) discards the in-flight operation; no response is produced after reset.
REQ-031 While rst_n is low, reqN_ready is 0.

Structure
REQ-032 Shared package alu_pkg holds:
- the 4-bit ALU control code constants (AND, OR, ADD, XOR, SLL, SRL, SUB, SRA, SLT, SLTU);
- the FSM state encoding;
- the legal-op limit.
REQ-033 A single sub-module rr_arbiter2 holds the 2-way round-robin picker, including prp. alu_arbiter instantiates it and holds the FSM and datapath registers.
REQ-034 The ALU is instantiated outside alu_arbiter and connected through the alu_* ports.

Verification
REQ-035 Bench scenarios:
- req0: ADD a=5, b=-5 -> rsp0 at T+2 with result 0, zero=1, carry=1, overflow=0, err=0.
- req0 and req1 both valid from reset: req0 ADD, req1 SUB 3-7 -> req0 is granted first; req1 is granted at the next IDLE with result -4, carry=1; prp toggles each time.
- req1: ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> overflow=1, carry=0; a following SLL op 1<<63 returns carry=0, overflow=0.
- op 1111 from req0 -> result 0, err=1, all other flags 0, response at T+2.
- rsp0_ready held low for 5 cycles -> rsp0 is stable; req1 is not granted until the handshake completes.
- rst_n pulsed low during ISSUE -> no rsp0_valid afterwards; state is IDLE and prp=0.
